// File: rtl/ahb_arb_pkg.sv
// Shared types and helpers for the AHB requester arbiter.
//   arb_state_t : arbiter FSM states (idle/arbitrating vs. grant locked)
//   RD / WR     : command direction encodings on *_rd0_wr1
//   next_rr()   : round-robin winner search over up to RR_MAX_REQ requesters
package ahb_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  localparam int unsigned RR_MAX_REQ = 8;

  // Search starts one above ptr and wraps at n; the first set bit wins.
  // Callers must check that req_vec is non-zero before using the result.
  function automatic logic [2:0] next_rr(input logic [2:0]  ptr,
                                         input logic [7:0]  req_vec,
                                         input int unsigned n = RR_MAX_REQ);
    logic [2:0]  win;
    logic        found;
    int unsigned idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= RR_MAX_REQ; i++) begin
      if (i <= n) begin
        idx = 32'(ptr) + i;
        if (idx >= n) idx = idx - n;
        if (!found && req_vec[3'(idx)]) begin
          win   = 3'(idx);
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/ahb_arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding reads.
//   i_clk/i_rst : clock, async active-high reset (empties the FIFO)
//   i_push/i_id : enqueue an ID (ignored when full and not popping)
//   i_pop       : dequeue the head (ignored when empty)
//   o_head      : current head ID
//   o_count     : number of stored IDs (0..DEPTH)
//   o_full/o_empty : status flags
module ahb_arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [ID_W-1:0]        i_id,
  input  logic                   i_pop,
  output logic [ID_W-1:0]        o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  import ahb_arb_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_count = count_q;
  assign o_head  = mem_q[rd_ptr_q];

  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_id;
  end

endmodule

// File: rtl/ahb_req_arbiter.sv
// Round-robin arbiter sharing one AHB master command port among NUM_REQ
// requesters, with in-order steering of read data back to the issuer.
//   i_clk_ahb/i_rst_ahb : clock, async active-high reset
//   i_req_*             : per-requester flattened command (valid/dir/addr/wdata)
//   o_req_ready         : one-hot accept pulse to the winner
//   o_req_rd_valid/o_req_rd_data : one-hot read return, broadcast data
//   o_m_*/i_m_ready     : command valid/ready to the AHB master
//   i_m_rd_valid/i_m_rd_data : in-order read responses from the master
//   o_grant_id          : requester currently driving the master port
//   o_busy              : grant locked or reads outstanding
//   o_rsp_err           : pulse on a read response with nothing outstanding
module ahb_req_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic                            i_clk_ahb,
  input  logic                            i_rst_ahb,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ-1:0]              i_req_rd0_wr1,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_wr_data,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic [NUM_REQ-1:0]              o_req_rd_valid,
  output logic [DATA_WIDTH-1:0]           o_req_rd_data,
  output logic                            o_m_valid,
  output logic                            o_m_rd0_wr1,
  output logic [ADDR_WIDTH-1:0]           o_m_addr,
  output logic [DATA_WIDTH-1:0]           o_m_wr_data,
  input  logic                            i_m_ready,
  input  logic [DATA_WIDTH-1:0]           i_m_rd_data,
  input  logic                            i_m_rd_valid,
  output logic [$clog2(NUM_REQ)-1:0]      o_grant_id,
  output logic                            o_busy,
  output logic                            o_rsp_err
);
  import ahb_arb_pkg::*;

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_OUTST) + 1;

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  grant_q, grant_d;

  logic [NUM_REQ-1:0] elig;
  logic [7:0]         elig_ext;
  logic [ID_W-1:0]    arb_win, sel;
  logic               hold, m_valid, accept, push, pop;

  logic [ID_W-1:0]    fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty;

  ahb_arb_id_fifo #(
    .DEPTH (MAX_OUTST),
    .ID_W  (ID_W)
  ) u_id_fifo (
    .i_clk   (i_clk_ahb),
    .i_rst   (i_rst_ahb),
    .i_push  (push),
    .i_id    (sel),
    .i_pop   (pop),
    .o_head  (fifo_head),
    .o_count (fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Command path. Outputs are also gated by reset so they read 0 while the
  // reset is held, even with requesters still asserting valid.
  always_comb begin
    elig     = i_req_valid & (i_req_rd0_wr1 | {NUM_REQ{~fifo_full}});
    elig_ext = '0;
    elig_ext[NUM_REQ-1:0] = elig;
    arb_win  = ID_W'(next_rr(3'(rr_ptr_q), elig_ext, NUM_REQ));
    hold     = (state_q == ARB_HOLD);
    sel      = hold ? grant_q : arb_win;
    m_valid  = !i_rst_ahb && (hold || (|elig));
    accept   = m_valid && i_m_ready;

    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    push        = 1'b0;
    o_req_ready = '0;

    if (accept) begin
      o_req_ready[sel] = 1'b1;
      rr_ptr_d         = sel;
      push             = (i_req_rd0_wr1[sel] == RD);
      state_d          = ARB_IDLE;
    end else if (m_valid) begin
      grant_d = sel;
      state_d = ARB_HOLD;
    end

    o_m_valid   = m_valid;
    o_grant_id  = m_valid ? sel : '0;
    o_m_rd0_wr1 = m_valid ? i_req_rd0_wr1[sel] : 1'b0;
    o_m_addr    = m_valid ? i_req_addr[32'(sel)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    o_m_wr_data = m_valid ? i_req_wr_data[32'(sel)*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  // Read return path: emptiness is the registered count, so a response in
  // the same cycle as the first push is still flagged as an error.
  always_comb begin
    pop            = !i_rst_ahb && i_m_rd_valid && !fifo_empty;
    o_rsp_err      = !i_rst_ahb && i_m_rd_valid && fifo_empty;
    o_req_rd_valid = '0;
    o_req_rd_valid[fifo_head] = pop;
    o_req_rd_data  = pop ? i_m_rd_data : '0;
  end

  assign o_busy = (state_q == ARB_HOLD) || (fifo_count != '0);

  always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
    if (i_rst_ahb) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= ID_W'(NUM_REQ - 1);
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

endmodule

// File: tb/tb_ahb_req_arbiter.sv
module tb_ahb_req_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_rw;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wd;
  logic [NR-1:0]     req_ready, req_rd_valid;
  logic [DW-1:0]     req_rd_data;
  logic              m_valid, m_rw, m_ready, m_rd_valid;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wd, m_rd_data;
  logic [1:0]        grant_id;
  logic              busy, rsp_err;

  ahb_req_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MAX_OUTST  (MO)
  ) dut (
    .i_clk_ahb      (clk),
    .i_rst_ahb      (rst),
    .i_req_valid    (req_valid),
    .i_req_rd0_wr1  (req_rw),
    .i_req_addr     (req_addr),
    .i_req_wr_data  (req_wd),
    .o_req_ready    (req_ready),
    .o_req_rd_valid (req_rd_valid),
    .o_req_rd_data  (req_rd_data),
    .o_m_valid      (m_valid),
    .o_m_rd0_wr1    (m_rw),
    .o_m_addr       (m_addr),
    .o_m_wr_data    (m_wd),
    .i_m_ready      (m_ready),
    .i_m_rd_data    (m_rd_data),
    .i_m_rd_valid   (m_rd_valid),
    .o_grant_id     (grant_id),
    .o_busy         (busy),
    .o_rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  // Reference model: queue of requester IDs owed a read response, the
  // requester holding a locked grant (-1 if none), and the last served one.
  int mq[$];
  int locked;
  int last;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    locked = -1;
    last   = NR - 1;
  endtask

  task automatic post(input int k, input logic rw, input logic [31:0] a, input logic [31:0] d);
    if (!req_valid[k]) begin
      req_valid[k]          = 1'b1;
      req_rw[k]             = rw;
      req_addr[k*AW +: AW]  = a;
      req_wd[k*DW +: DW]    = d;
    end
  endtask

  // One clock: check every output against the model at the falling edge,
  // advance the model at the rising edge, retire completed commands.
  task automatic step();
    int            w;
    bit            mv, pop;
    logic [NR-1:0] exp_rdy, exp_rdv;
    logic [DW-1:0] exp_data;
    logic          exp_err;
    @(negedge clk);
    if (rst) begin
      chk("rst_m_valid",  64'(m_valid), 0);
      chk("rst_ready",    64'(req_ready), 0);
      chk("rst_rd_valid", 64'(req_rd_valid), 0);
      chk("rst_err",      64'(rsp_err), 0);
      chk("rst_busy",     64'(busy), 0);
      chk("rst_grant",    64'(grant_id), 0);
      chk("rst_addr",     64'(m_addr), 0);
      model_reset();
      @(posedge clk);
      #1;
      return;
    end
    mv = 0; w = 0;
    if (locked >= 0) begin
      mv = 1; w = locked;
    end else begin
      for (int i = 1; i <= NR; i++) begin
        int k;
        k = (last + i) % NR;
        if (!mv && req_valid[k] && (req_rw[k] || mq.size() < MO)) begin
          mv = 1; w = k;
        end
      end
    end
    exp_rdy = '0;
    if (mv && m_ready) exp_rdy[w] = 1'b1;
    exp_rdv = '0; exp_data = '0; exp_err = 1'b0; pop = 0;
    if (m_rd_valid) begin
      if (mq.size() > 0) begin
        exp_rdv[mq[0]] = 1'b1;
        exp_data = m_rd_data;
        pop = 1;
      end else begin
        exp_err = 1'b1;
      end
    end
    chk("m_valid",  64'(m_valid), 64'(mv));
    chk("grant_id", 64'(grant_id), mv ? 64'(w) : 0);
    chk("m_addr",   64'(m_addr), mv ? 64'(req_addr[w*AW +: AW]) : 0);
    chk("m_wdata",  64'(m_wd),   mv ? 64'(req_wd[w*DW +: DW]) : 0);
    chk("m_rw",     64'(m_rw),   mv ? 64'(req_rw[w]) : 0);
    chk("ready",    64'(req_ready), 64'(exp_rdy));
    chk("rd_valid", 64'(req_rd_valid), 64'(exp_rdv));
    chk("rd_data",  64'(req_rd_data), 64'(exp_data));
    chk("rsp_err",  64'(rsp_err), 64'(exp_err));
    chk("busy",     64'(busy), 64'(locked >= 0 || mq.size() != 0));
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (mv && m_ready) begin
      if (!req_rw[w]) mq.push_back(w);
      last   = w;
      locked = -1;
    end else if (mv) begin
      locked = w;
    end
    #1;
    if (exp_rdy != '0) req_valid[w] = 1'b0;
  endtask

  // Let the master accept and answer everything until idle (bounded).
  task automatic drain();
    m_ready    = 1'b1;
    m_rd_valid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (mq.size() == 0 && req_valid == '0 && locked < 0) break;
      m_rd_valid = (mq.size() != 0);
      m_rd_data  = $urandom;
      step();
    end
    chk("drain_idle", 64'(mq.size() == 0 && req_valid == '0 && locked < 0), 1);
    m_rd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_rw = '0; req_addr = '0; req_wd = '0;
    m_ready = 1'b0; m_rd_valid = 1'b0; m_rd_data = '0;
    model_reset();
    step();
    step();
    rst = 1'b0;

    // Single write from req1, accepted in the same cycle.
    m_ready = 1'b1;
    post(1, 1'b1, 32'h100, 32'hDEAD);
    #1;
    chk("t1_ready", 64'(req_ready), 64'h2);
    chk("t1_addr",  64'(m_addr), 64'h100);
    step();

    // req0 and req2 reads back-to-back; responses start one cycle later.
    for (int n = 0; n < 8; n++) begin
      post(0, 1'b0, 32'h1000 + n, 32'h0);
      post(2, 1'b0, 32'h2000 + n, 32'h0);
      m_rd_valid = (n > 0);
      m_rd_data  = $urandom;
      step();
    end
    drain();

    // req3 stalled for 3 cycles, req0 arrives meanwhile.
    m_ready = 1'b0;
    post(3, 1'b0, 32'h3333, 32'h0);
    step();
    post(0, 1'b0, 32'h0A0A, 32'h0);
    step();
    step();
    #1;
    chk("t3_locked", 64'(grant_id), 3);
    m_ready = 1'b1;
    step();
    chk("t3_next", 64'(grant_id), 0);
    step();
    drain();

    // Fill the FIFO, then a blocked read and an unblocked write.
    for (int n = 0; n < MO; n++) begin
      post(0, 1'b0, 32'h40 + n, 32'h0);
      step();
    end
    post(1, 1'b0, 32'h5000, 32'h0);
    post(2, 1'b1, 32'h6000, 32'hBEEF);
    #1;
    chk("t4_write_wins", 64'(req_ready), 64'h4);
    step();
    m_rd_valid = 1'b1; m_rd_data = 32'h1234;
    step();
    m_rd_valid = 1'b0;
    #1;
    chk("t4_read_freed", 64'(req_ready), 64'h2);
    step();
    drain();

    // Push and pop in one cycle with two outstanding; then a stray response.
    post(0, 1'b0, 32'h70, 32'h0); step();
    post(1, 1'b0, 32'h71, 32'h0); step();
    post(2, 1'b0, 32'h72, 32'h0);
    m_rd_valid = 1'b1; m_rd_data = 32'hCAFE;
    #1;
    chk("t5_old_head", 64'(req_rd_valid), 64'h1);
    step();
    chk("t5_count", 64'(mq.size()), 2);
    drain();
    m_rd_valid = 1'b1; m_rd_data = 32'h5555;
    #1;
    chk("t5_err", 64'(rsp_err), 1);
    step();
    m_rd_valid = 1'b0;

    // Asynchronous reset while holding a grant with two reads outstanding.
    post(0, 1'b0, 32'h80, 32'h0); step();
    post(1, 1'b0, 32'h81, 32'h0); step();
    m_ready = 1'b0;
    post(2, 1'b0, 32'h82, 32'h0); step();
    #1 rst = 1'b1;
    #1;
    chk("ar_m_valid", 64'(m_valid), 0);
    chk("ar_busy",    64'(busy), 0);
    chk("ar_ready",   64'(req_ready), 0);
    step();
    rst = 1'b0;
    req_valid = '0;
    m_ready = 1'b1;
    for (int k = 0; k < NR; k++) post(k, 1'b0, 32'h900 + k, 32'h0);
    #1;
    chk("ar_first_grant", 64'(grant_id), 0);
    step();
    drain();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NR; k++)
        if (!req_valid[k] && $urandom_range(0, 2) == 0)
          post(k, 1'(  $urandom_range(0, 1)), $urandom, $urandom);
      m_ready    = ($urandom_range(0, 3) != 0);
      m_rd_valid = ($urandom_range(0, 2) == 0);
      m_rd_data  = $urandom;
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
